// File: rtl/nios_sample_tick_gen.sv
// nios_sample_tick_gen
//
// Avalon-MM slave that drives a WIDTH-bit output port either as a
// software-written value (manual mode) or as one-cycle ticks, gated by a
// channel mask, from a programmable down-counter (periodic mode). It keeps a
// sticky PENDING flag, an OVERRUN flag, a 32-bit tick counter and a level
// interrupt so the CPU can pace accelerometer sampling.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous, active-low reset
//   address     register select (0 DATA, 1 CONTROL, 2 PERIOD, 3 STATUS,
//               4 TICK_COUNT, 5 SET, 6 CLR, 7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data, zero wait states
//   out_port    channel outputs
//   tick        registered one-cycle tick pulse
//   irq         level interrupt (IRQ_EN & PENDING)

module nios_sample_tick_gen #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      CNT_W       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             tick,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_CONTROL    = 3'd1;
    localparam logic [2:0] ADDR_PERIOD     = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_TICK_COUNT = 3'd4;
    localparam logic [2:0] ADDR_SET        = 3'd5;
    localparam logic [2:0] ADDR_CLR        = 3'd6;

    logic [WIDTH-1:0] data_q;
    logic             run_q;
    logic             mode_q;
    logic             irq_en_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             pending_q;
    logic             overrun_q;
    logic [31:0]      tick_count_q;

    logic wr_en;
    logic wr_data;
    logic wr_control;
    logic wr_period;
    logic wr_status;
    logic wr_tick_count;
    logic wr_set;
    logic wr_clr;
    logic run_next;
    logic run_start;
    logic counting;
    logic tick_set;
    logic clr_pending;
    logic clr_overrun;

    // Upper writedata bits beyond WIDTH/CNT_W are deliberately ignored.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_en         = chipselect & ~write_n;
    assign wr_data       = wr_en && (address == ADDR_DATA);
    assign wr_control    = wr_en && (address == ADDR_CONTROL);
    assign wr_period     = wr_en && (address == ADDR_PERIOD);
    assign wr_status     = wr_en && (address == ADDR_STATUS);
    assign wr_tick_count = wr_en && (address == ADDR_TICK_COUNT);
    assign wr_set        = wr_en && (address == ADDR_SET);
    assign wr_clr        = wr_en && (address == ADDR_CLR);

    // A CONTROL write that clears RUN stops the counter on that same edge,
    // so the tick is already low in the following cycle.
    assign run_next  = wr_control ? writedata[0] : run_q;
    assign run_start = wr_control & writedata[0] & ~run_q;
    assign counting  = run_q & run_next;
    assign tick_set  = counting && (cnt_q == '0);

    assign clr_pending = wr_status & writedata[0];
    assign clr_overrun = wr_status & writedata[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            period_q <= '0;
        end else begin
            if (wr_control) begin
                run_q    <= writedata[0];
                mode_q   <= writedata[1];
                irq_en_q <= writedata[2];
            end
            if (wr_period) begin
                period_q <= writedata[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else if (wr_data) begin
            data_q <= writedata[WIDTH-1:0];
        end else if (wr_set) begin
            data_q <= data_q | writedata[WIDTH-1:0];
        end else if (wr_clr) begin
            data_q <= data_q & ~writedata[WIDTH-1:0];
        end
    end

    // Reloads always take the PERIOD register at reload time, so a PERIOD
    // write mid-interval only shapes the interval after the next tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (run_start) begin
            cnt_q  <= period_q;
            tick_q <= 1'b0;
        end else if (counting) begin
            if (cnt_q == '0) begin
                cnt_q  <= period_q;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q - CNT_W'(1);
                tick_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    // A tick wins over a same-edge W1C of PENDING; OVERRUN is only raised
    // when the previous tick was still unacknowledged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= tick_set | (pending_q & ~clr_pending);
            overrun_q <= (overrun_q & ~clr_overrun)
                       | (tick_set & pending_q & ~clr_pending);
        end
    end

    // A write clears the count, but a tick on the same edge still counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_count_q <= '0;
        end else if (wr_tick_count) begin
            tick_count_q <= tick_set ? 32'd1 : 32'd0;
        end else if (tick_set) begin
            tick_count_q <= tick_count_q + 32'd1;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata = 32'(data_q);
            ADDR_CONTROL:    readdata = {29'd0, irq_en_q, mode_q, run_q};
            ADDR_PERIOD:     readdata = 32'(period_q);
            ADDR_STATUS:     readdata = {30'd0, overrun_q, pending_q};
            ADDR_TICK_COUNT: readdata = tick_count_q;
            default:         readdata = '0;
        endcase
    end

    assign out_port = mode_q ? (data_q & {WIDTH{tick_q}}) : data_q;
    assign tick     = tick_q;
    assign irq      = irq_en_q & pending_q;

endmodule

// File: tb/tb_nios_sample_tick_gen.sv
// Testbench for nios_sample_tick_gen (WIDTH=4, CNT_W=8, RESET_VALUE=4'hA).
// The reference model schedules ticks as absolute edge numbers rather than
// tracking a down-counter.

module tb_nios_sample_tick_gen;

    localparam int         WIDTH   = 4;
    localparam int         CNT_W   = 8;
    localparam logic [3:0] RST_VAL = 4'hA;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             tick;
    logic             irq;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_num     = 0;
    int tick_edges[$];

    // Reference model state
    logic [3:0]  m_data;
    logic        m_run;
    logic        m_mode;
    logic        m_irqen;
    logic [7:0]  m_period;
    logic        m_pending;
    logic        m_overrun;
    logic [31:0] m_tc;
    logic        m_tick;
    int          m_next_tick;

    nios_sample_tick_gen #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .RESET_VALUE (RST_VAL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .tick       (tick),
        .irq        (irq)
    );

    always #20 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        m_data      = RST_VAL;
        m_run       = 1'b0;
        m_mode      = 1'b0;
        m_irqen     = 1'b0;
        m_period    = 8'd0;
        m_pending   = 1'b0;
        m_overrun   = 1'b0;
        m_tc        = 32'd0;
        m_tick      = 1'b0;
        m_next_tick = 0;
    endtask

    function automatic logic [31:0] modelRead(input logic [2:0] a);
        case (a)
            3'd0:    return {28'd0, m_data};
            3'd1:    return {29'd0, m_irqen, m_mode, m_run};
            3'd2:    return {24'd0, m_period};
            3'd3:    return {30'd0, m_overrun, m_pending};
            3'd4:    return m_tc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelEdge(input bit do_wr, input logic [2:0] a, input logic [31:0] wd);
        bit wr_ctrl;
        bit new_run;
        bit fire;
        bit clr_p;
        bit clr_o;
        wr_ctrl = do_wr && (a == 3'd1);
        new_run = wr_ctrl ? wd[0] : m_run;
        fire    = 1'b0;
        if (wr_ctrl && wd[0] && !m_run) begin
            m_next_tick = edge_num + int'(m_period) + 1;
        end else if (m_run && new_run && (edge_num == m_next_tick)) begin
            fire        = 1'b1;
            m_next_tick = edge_num + int'(m_period) + 1;
        end
        clr_p = do_wr && (a == 3'd3) && wd[0];
        clr_o = do_wr && (a == 3'd3) && wd[1];
        m_overrun = (m_overrun && !clr_o) || (fire && m_pending && !clr_p);
        m_pending = fire || (m_pending && !clr_p);
        if (do_wr && (a == 3'd4)) m_tc = fire ? 32'd1 : 32'd0;
        else if (fire)             m_tc = m_tc + 32'd1;
        if (do_wr) begin
            case (a)
                3'd0:    m_data = wd[3:0];
                3'd1:    {m_irqen, m_mode, m_run} = wd[2:0];
                3'd2:    m_period = wd[7:0];
                3'd5:    m_data = m_data | wd[3:0];
                3'd6:    m_data = m_data & ~wd[3:0];
                default: ;
            endcase
        end
        m_tick = fire;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given bus cycle; leaves time at the next negedge.
    task automatic applyStimulus(input bit do_wr, input logic [2:0] a, input logic [31:0] wd);
        address    = a;
        writedata  = wd;
        chipselect = do_wr;
        write_n    = !do_wr;
        @(posedge clk);
        modelEdge(do_wr, a, wd);
        edge_num++;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        if (tick === 1'b1) tick_edges.push_back(edge_num - 1);
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] exp_out;
        exp_out = m_mode ? (m_data & {4{m_tick}}) : m_data;
        checkValue({tag, ".out_port"}, 32'(out_port), 32'(exp_out));
        checkValue({tag, ".tick"}, 32'(tick), 32'(m_tick));
        checkValue({tag, ".irq"}, 32'(irq), 32'(m_irqen & m_pending));
    endtask

    task automatic checkRead(input logic [2:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        checkValue($sformatf("read%0d", a), readdata, modelRead(a));
        chipselect = 1'b0;
    endtask

    task automatic readAll();
        for (int a = 0; a < 8; a++) checkRead(3'(a));
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [31:0] wd);
        applyStimulus(1'b1, a, wd);
        checkOutput($sformatf("wr%0d", a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0);
            checkOutput("idle");
        end
    endtask

    // Idles until the next bus cycle will land on a tick edge.
    task automatic waitForTickEdge(input string tag);
        int g;
        g = 0;
        while ((edge_num != m_next_tick) && (g < 100)) begin
            idle(1);
            g++;
        end
        checkValue({tag, ".tick_wait"}, 32'(edge_num == m_next_tick), 32'd1);
    endtask

    int n_ticks;

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset");
        checkValue("reset.out_const", 32'(out_port), 32'hA);
        readAll();
        reset_n = 1'b1;
        idle(2);

        // Manual mode
        busWrite(3'd0, 32'h5);
        checkValue("manual.data", 32'(out_port), 32'h5);
        busWrite(3'd5, 32'h2);
        checkValue("manual.set", 32'(out_port), 32'h7);
        busWrite(3'd6, 32'h4);
        checkValue("manual.clr", 32'(out_port), 32'h3);
        checkRead(3'd5);
        checkValue("manual.read5", readdata, 32'd0);

        // Periodic timing: tick every 4 cycles
        busWrite(3'd2, 32'd3);
        busWrite(3'd0, 32'hF);
        busWrite(3'd1, 32'h3);
        n_ticks = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (tick === 1'b1) begin
                n_ticks++;
                checkValue("periodic.out", 32'(out_port), 32'hF);
            end
            if (i == 2) checkValue("periodic.first_not_yet", 32'(tick), 32'd0);
            if (i == 3) checkValue("periodic.first_tick", 32'(tick), 32'd1);
        end
        checkValue("periodic.count", 32'(n_ticks), 32'd5);
        checkRead(3'd4);
        checkValue("periodic.tick_count", readdata, 32'd5);

        // Interrupt and overrun
        busWrite(3'd1, 32'h0);
        busWrite(3'd3, 32'h3);
        busWrite(3'd4, 32'h0);
        busWrite(3'd2, 32'd9);
        busWrite(3'd1, 32'h7);
        waitForTickEdge("irq1");
        idle(1);
        checkValue("irq.first", 32'(irq), 32'd1);
        checkRead(3'd3);
        checkValue("irq.status1", readdata, 32'h1);
        waitForTickEdge("irq2");
        idle(1);
        checkRead(3'd3);
        checkValue("irq.overrun", readdata, 32'h3);
        busWrite(3'd3, 32'h3);
        checkValue("irq.cleared", 32'(irq), 32'd0);
        checkRead(3'd3);
        checkValue("irq.status0", readdata, 32'h0);

        // Collisions on the tick edge
        waitForTickEdge("coll1");
        busWrite(3'd3, 32'h1);
        checkRead(3'd3);
        checkValue("coll.w1c", readdata, 32'h1);
        waitForTickEdge("coll2");
        busWrite(3'd4, 32'h1234);
        checkRead(3'd4);
        checkValue("coll.tick_count", readdata, 32'd1);

        // Reload: PERIOD 3 -> 7 mid-run
        busWrite(3'd1, 32'h0);
        busWrite(3'd2, 32'd3);
        tick_edges.delete();
        busWrite(3'd1, 32'h3);
        idle(9);
        busWrite(3'd2, 32'd7);
        idle(30);
        checkValue("reload.n", 32'(tick_edges.size()), 32'd6);
        if (tick_edges.size() == 6) begin
            checkValue("reload.gap0", 32'(tick_edges[1] - tick_edges[0]), 32'd4);
            checkValue("reload.gap1", 32'(tick_edges[2] - tick_edges[1]), 32'd4);
            for (int i = 2; i < 5; i++)
                checkValue("reload.gap8", 32'(tick_edges[i+1] - tick_edges[i]), 32'd8);
        end

        // Stop, then restart reloads from PERIOD
        busWrite(3'd1, 32'h0);
        tick_edges.delete();
        idle(20);
        checkValue("stop.no_ticks", 32'(tick_edges.size()), 32'd0);
        busWrite(3'd1, 32'h3);
        idle(7);
        checkValue("restart.not_yet", 32'(tick), 32'd0);
        idle(1);
        checkValue("restart.tick", 32'(tick), 32'd1);

        // PERIOD=0: continuous tick, overrun from the second tick
        busWrite(3'd1, 32'h0);
        busWrite(3'd3, 32'h3);
        busWrite(3'd2, 32'd0);
        busWrite(3'd1, 32'h3);
        idle(1);
        checkRead(3'd3);
        checkValue("p0.first_status", readdata, 32'h1);
        idle(3);
        checkValue("p0.tick", 32'(tick), 32'd1);
        checkRead(3'd3);
        checkValue("p0.status", readdata, 32'h3);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            bit          do_wr;
            do_wr = ($urandom_range(0, 3) != 0);
            a     = 3'($urandom_range(0, 7));
            wd    = $urandom;
            if (a == 3'd2) wd = 32'($urandom_range(0, 6));
            applyStimulus(do_wr, a, wd);
            checkOutput("rand");
            checkRead(3'($urandom_range(0, 7)));
        end

        // Asynchronous reset mid-run
        busWrite(3'd2, 32'd2);
        busWrite(3'd1, 32'h7);
        idle(3);
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        readAll();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
